// File: rtl/elevator_call_latch_if.sv
// rtl/elevator_call_latch_if.sv - hall-button / request bundle for elevator_call_latch
// master drives buttons and car floor; slave returns requests, door and call status.
interface elevator_call_latch_if;
  logic [3:0] btn;
  logic [1:0] floor;
  logic [3:0] req;
  logic       door_open;
  logic [3:0] pending;

  modport master (output btn, floor, input req, door_open, pending);
  modport slave  (input btn, floor, output req, door_open, pending);
endinterface

// File: rtl/elevator_call_latch.sv
// rtl/elevator_call_latch.sv - hall-call latch with door-dwell timer for a four-floor car
// Define BTN_SYNC_EN to pass btn through a two-flop synchronizer before edge detection.
module elevator_call_latch #(
  parameter int DWELL   = 8,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  elevator_call_latch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_LOAD = DWELL_W'(DWELL - 1);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         btn_prev_q, btn_prev_d;
  logic [3:0]         pending_q, pending_d;
  logic [1:0]         floor_q, floor_d;
  logic [1:0]         stop_floor_q, stop_floor_d;
  logic [3:0]         btn_s;
  logic [3:0]         rise;
  logic [3:0]         clr;
  logic [3:0]         req_c;
  logic               door_c;

`ifdef BTN_SYNC_EN
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.btn;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = bus.btn;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stop_floor_d = stop_floor_q;
    clr          = '0;
    req_c        = pending_q;
    door_c       = 1'b0;
    rise         = btn_s & ~btn_prev_q;
    btn_prev_d   = btn_s;
    floor_d      = bus.floor;

    case (state_q)
      IDLE: begin
        if (pending_q[bus.floor] && (bus.floor == floor_q)) begin
          state_d      = OPEN;
          cnt_d        = CNT_LOAD;
          stop_floor_d = bus.floor;
        end
      end
      OPEN: begin
        // Holding only the stop floor's request keeps the controller parked here.
        door_c = 1'b1;
        req_c  = 4'b0001 << stop_floor_q;
        if (rise[stop_floor_q]) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d           = CLOSE;
          clr[stop_floor_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      CLOSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New presses win over the dwell-complete clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      btn_prev_q   <= '0;
      pending_q    <= '0;
      floor_q      <= '0;
      stop_floor_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      btn_prev_q   <= btn_prev_d;
      pending_q    <= pending_d;
      floor_q      <= floor_d;
      stop_floor_q <= stop_floor_d;
    end
  end

  assign bus.req       = req_c;
  assign bus.door_open = door_c;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_elevator_call_latch.sv
// tb/tb_elevator_call_latch.sv - directed bench for elevator_call_latch with a behavioural call model
// The model tracks remaining door-open cycles and a post-close guard cycle per the call rules.
module tb_elevator_call_latch;

  localparam int DWELL = 8;
`ifdef BTN_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  elevator_call_latch_if bus ();

  elevator_call_latch #(.DWELL(DWELL), .DWELL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic [1:0] m_floor_prev;
  logic [3:0] m_s1, m_s2;
  int         m_left;
  bit         m_guard;
  int         m_stop;

  task automatic model_reset();
    m_pend       = '0;
    m_prev       = '0;
    m_floor_prev = '0;
    m_s1         = '0;
    m_s2         = '0;
    m_left       = 0;
    m_guard      = 1'b0;
    m_stop       = 0;
  endtask

  task automatic model_step();
    logic [3:0] b;
    logic [3:0] r;
    if (!rst) begin
      model_reset();
      return;
    end
    if (SYNC != 0) begin
      b    = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.btn;
    end else begin
      b = bus.btn;
    end
    r = b & ~m_prev;
    if (m_left > 0) begin
      if (r[m_stop]) begin
        m_left = DWELL;
      end else if (m_left == 1) begin
        m_left         = 0;
        m_guard        = 1'b1;
        m_pend[m_stop] = 1'b0;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_guard) begin
      m_guard = 1'b0;
    end else if (m_pend[bus.floor] && (bus.floor == m_floor_prev)) begin
      m_left = DWELL;
      m_stop = int'(bus.floor);
    end
    m_pend       = m_pend | r;
    m_prev       = b;
    m_floor_prev = bus.floor;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic tick();
    logic [3:0] e_req;
    logic       e_door;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e_door = (m_left > 0);
    e_req  = e_door ? 4'(1 << m_stop) : m_pend;
    chk("model_req", 8'(bus.req), 8'(e_req));
    chk("model_door", 8'(bus.door_open), 8'(e_door));
    chk("model_pending", 8'(bus.pending), 8'(m_pend));
  endtask

  int opened;
  bit seen;

  initial begin
    rst       = 1'b0;
    bus.btn   = '0;
    bus.floor = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("reset_req", 8'(bus.req), 8'h00);
    chk("reset_door", 8'(bus.door_open), 8'h00);
    chk("reset_pending", 8'(bus.pending), 8'h00);

    // Call for A while the car sits at C
    bus.floor = 2'd2;
    tick();
    bus.btn = 4'b0001;
    tick();
    bus.btn = '0;
    repeat (SYNC) tick();
    chk("far_call_req", 8'(bus.req), 8'h01);
    repeat (5) tick();
    chk("far_call_persist", 8'(bus.req), 8'h01);
    chk("far_call_door", 8'(bus.door_open), 8'h00);

    // Serve A by moving the car there
    bus.floor = 2'd0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.door_open) seen = 1'b1;
      if (seen && !bus.door_open) break;
    end
    chk("a_served_seen", 8'(seen), 8'h01);
    chk("a_served_pending", 8'(bus.pending), 8'h00);

    // Call at the current floor B, plus a D call during the dwell
    bus.floor = 2'd1;
    repeat (3) tick();
    bus.btn = 4'b0010;
    tick();
    bus.btn = '0;
    repeat (SYNC) tick();
    chk("b_call_pending", 8'(bus.pending), 8'h02);
    chk("b_call_door_early", 8'(bus.door_open), 8'h00);
    tick();
    chk("b_open_door", 8'(bus.door_open), 8'h01);
    opened = 1;
    bus.btn = 4'b1000;
    tick();
    opened++;
    bus.btn = '0;
    for (int i = 0; i < SYNC; i++) begin
      tick();
      opened++;
    end
    chk("d_during_open_pending", 8'(bus.pending), 8'h0a);
    chk("d_during_open_req", 8'(bus.req), 8'h02);
    for (int i = 0; i < 40 && bus.door_open; i++) begin
      tick();
      if (bus.door_open) opened++;
    end
    chk("b_dwell_len", 8'(opened), 8'(DWELL));
    chk("close_req", 8'(bus.req), 8'h08);
    chk("close_pending", 8'(bus.pending), 8'h08);
    chk("close_door", 8'(bus.door_open), 8'h00);
    tick();

    // Held button gives a single dwell
    bus.btn = 4'b0010;
    opened  = 0;
    repeat (24) begin
      tick();
      if (bus.door_open) opened++;
    end
    bus.btn = '0;
    repeat (4) begin
      tick();
      if (bus.door_open) opened++;
    end
    chk("hold_single_dwell", 8'(opened), 8'(DWELL));

    // Re-press during dwell cycle 6 extends the door time
    bus.btn = 4'b0010;
    tick();
    bus.btn = '0;
    repeat (SYNC) tick();
    tick();
    chk("repress_open", 8'(bus.door_open), 8'h01);
    opened = 1;
    for (int i = 0; i < 40 && bus.door_open; i++) begin
      bus.btn = (opened == 6) ? 4'b0010 : 4'b0000;
      tick();
      if (bus.door_open) opened++;
    end
    bus.btn = '0;
    chk("repress_dwell_len", 8'(opened), 8'(6 + SYNC + DWELL));
    tick();
    tick();

    // Floor change during OPEN is ignored, then async reset mid-dwell
    bus.btn = 4'b0010;
    tick();
    bus.btn = '0;
    repeat (SYNC) tick();
    tick();
    chk("pre_reset_open", 8'(bus.door_open), 8'h01);
    bus.floor = 2'd3;
    tick();
    tick();
    chk("moved_floor_req", 8'(bus.req), 8'h02);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_door", 8'(bus.door_open), 8'h00);
    chk("async_rst_req", 8'(bus.req), 8'h00);
    chk("async_rst_pending", 8'(bus.pending), 8'h00);
    model_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.floor = 2'd0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
